fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 Parameter MAX_OUT, 2, maximum in-flight memory requests plus buffered instructions.
REQ-003 CLK  input  1  clock; RESET input 1 reset: asynchronous, active-high.
REQ-004 FETCH_EN  input  1  permits new memory requests when high.
REQ-005 REDIRECT  input  1  one-cycle branch/exception flush pulse.
REQ-006 REDIRECT_PC  input  32  new fetch address, sampled when REDIRECT=1.
REQ-007 IMEM_REQ  output  1  memory request valid.
REQ-008 IMEM_ADDR  output  32  word address of the request.
REQ-009 IMEM_GNT  input  1  request accepted this cycle.
REQ-010 IMEM_RVALID  input  1  in-order response valid.
REQ-011 IMEM_RDATA  input  32  response instruction word.
REQ-012 STALL_IN  input  1  decode queue full; transfer blocked.
REQ-013 INSTR_VALID  output  1  INSTR_OUT/INSTR_PC_OUT hold a valid entry.
REQ-014 INSTR_OUT  output  32  instruction to the decode queue.
REQ-015 INSTR_PC_OUT  output  32  PC of INSTR_OUT.

Function
REQ-016 States: IDLE, FETCH, FLUSH; reset enters IDLE.
REQ-017 IDLE->FETCH when FETCH_EN=1; FETCH->IDLE when FETCH_EN=0 and no REDIRECT.
REQ-018 Any state -> FLUSH on REDIRECT=1; FLUSH->FETCH (or IDLE if FETCH_EN=0) the first cycle the outstanding count is 0 and REDIRECT=0.
REQ-019 IMEM_REQ=1 only in FETCH with outstanding+buffered < MAX_OUT; IMEM_ADDR=pc; pc, IMEM_ADDR and IMEM_REQ combinational on registered state.
REQ-020 On IMEM_REQ&IMEM_GNT: pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding +1.
REQ-021 Each IMEM_RVALID decrements outstanding; tracked PC FIFO supplies PC of the response.
REQ-022 Response outside FLUSH is written to the 2-entry output buffer; visible on outputs the next cycle (1-cycle RVALID->INSTR_VALID latency).
REQ-023 Response arriving in FLUSH, or in the cycle REDIRECT=1, is discarded.
REQ-024 Transfer occurs when INSTR_VALID=1 and STALL_IN=0; buffer head pops same edge; outputs hold stable while STALL_IN=1.
REQ-025 Credit excludes same-cycle pop; simultaneous RVALID write and pop both take effect.
REQ-026 REDIRECT: buffer cleared, INSTR_VALID=0 next cycle, pc <= REDIRECT_PC; a request granted in the same cycle counts as outstanding and its response is discarded.
REQ-027 REDIRECT while in FLUSH: replaces target PC, remains in FLUSH.
REQ-028 REDIRECT_PC[1:0] ignored (forced to 00).

Reset
REQ-029 RESET clears state to IDLE, pc=RESET_PC, outstanding=0, buffer empty, INSTR_VALID=0, IMEM_REQ=0, INSTR_OUT=0, INSTR_PC_OUT=0, immediately and asynchronously.
REQ-030 Memory is reset concurrently; no responses are expected for pre-reset requests.

Configuration
REQ-031 Macro FETCH_UNIT_TRACE_EN defined: $display each grant (address), each transfer (instruction, PC), each discarded response and each REDIRECT target.
REQ-032 Macro undefined: no display statements compiled; identical cycle behaviour.

Structure
REQ-033 Shared package mips_pkg holds RESET_PC default, XLEN=32, fetch state enum (IDLE/FETCH/FLUSH).
REQ-034 Sub-module fetch_buf: 2-entry FIFO of {instr, pc} with push, pop, clear, count; instantiated for output buffer and reused as in-flight PC tracker.

Verification
REQ-035 Reset, FETCH_EN=1, GNT=1 every cycle, RVALID one cycle later -> addresses BFC00000, BFC00004, BFC00008; INSTR_VALID with matching PCs 2 cycles after each grant.
REQ-036 STALL_IN held 1 for 10 cycles -> exactly 2 requests granted, INSTR_OUT stable; release -> both entries delivered in order, no loss or duplicate.
REQ-037 REDIRECT to 0x0000_0100 with 2 requests outstanding -> both responses discarded, INSTR_VALID=0, next IMEM_ADDR=0x100 only after outstanding reaches 0.
REQ-038 REDIRECT coincident with grant and RVALID -> that response and the in-flight one dropped; first delivered PC equals REDIRECT_PC.
REQ-039 REDIRECT_PC=0xFFFF_FFF8 -> fetch addresses FFFFFFF8, FFFFFFFC, 00000000.
REQ-040 RESET asserted mid-FETCH with full buffer -> INSTR_VALID and IMEM_REQ low immediately; after release first address is BFC00000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice: data width, reset vector,
// fetch FSM states and the {instr, pc} entry carried by the fetch buffers.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFlush
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel plus the decode-queue transfer
// channel of the fetch unit.
interface fetch_unit_if;
    import mips_pkg::*;

    logic            IMEM_REQ;
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_GNT;
    logic            IMEM_RVALID;
    logic [XLEN-1:0] IMEM_RDATA;
    logic            STALL_IN;
    logic            INSTR_VALID;
    logic [XLEN-1:0] INSTR_OUT;
    logic [XLEN-1:0] INSTR_PC_OUT;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_GNT,
        input  IMEM_RVALID,
        input  IMEM_RDATA,
        input  STALL_IN,
        output INSTR_VALID,
        output INSTR_OUT,
        output INSTR_PC_OUT
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_GNT,
        output IMEM_RVALID,
        output IMEM_RDATA,
        output STALL_IN,
        input  INSTR_VALID,
        input  INSTR_OUT,
        input  INSTR_PC_OUT
    );

endinterface

// File: rtl/fetch_buf.sv
// Small FIFO of {instr, pc} entries with synchronous clear; used both as the
// output buffer and as the tracker of PCs for in-flight memory requests.
module fetch_buf
    import mips_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CntW'(Depth)) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches under a credit limit,
// buffers in-order responses for decode and flushes stale responses on REDIRECT.
// Define FETCH_UNIT_TRACE_EN to print grants, transfers, discards and redirects.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     MAX_OUT  = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FETCH_EN,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_PC,
    fetch_unit_if.master    bus
);

    localparam int unsigned   CntW    = $clog2(MAX_OUT + 1);
    localparam logic [CntW:0] MaxOutC = (CntW + 1)'(MAX_OUT);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] out_cnt, buf_cnt;
    logic [CntW:0]   in_use;
    fetch_entry_t    trk_push, trk_head, buf_push, buf_head;
    logic            req, grant, xfer, resp_keep;
    logic            unused_trk_instr;

    // Credit counts what is in flight plus what is buffered, ignoring a same-cycle pop.
    assign in_use    = {1'b0, out_cnt} + {1'b0, buf_cnt};
    assign req       = (state_q == StFetch) && (in_use < MaxOutC);
    assign grant     = req && bus.IMEM_GNT;
    assign xfer      = (buf_cnt != '0) && !bus.STALL_IN;
    assign resp_keep = bus.IMEM_RVALID && (state_q != StFlush) && !REDIRECT;

    assign trk_push         = '{instr: '0, pc: pc_q};
    assign buf_push         = '{instr: bus.IMEM_RDATA, pc: trk_head.pc};
    assign unused_trk_instr = ^trk_head.instr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (FETCH_EN) state_d = StFetch;
            StFetch: if (!FETCH_EN) state_d = StIdle;
            StFlush: if (out_cnt == '0) state_d = FETCH_EN ? StFetch : StIdle;
            default: state_d = StIdle;
        endcase
        if (REDIRECT) begin
            state_d = StFlush;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (REDIRECT) begin
            pc_d = word_align(REDIRECT_PC);
        end else if (grant) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // In-flight tracker: one entry per granted request, retired by each response.
    fetch_buf #(
        .Depth (MAX_OUT)
    ) u_tracker (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .clear_i     (1'b0),
        .push_i      (grant),
        .push_data_i (trk_push),
        .pop_i       (bus.IMEM_RVALID),
        .head_o      (trk_head),
        .count_o     (out_cnt)
    );

    fetch_buf #(
        .Depth (MAX_OUT)
    ) u_out_buf (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .clear_i     (REDIRECT),
        .push_i      (resp_keep),
        .push_data_i (buf_push),
        .pop_i       (xfer),
        .head_o      (buf_head),
        .count_o     (buf_cnt)
    );

    assign bus.IMEM_REQ     = req;
    assign bus.IMEM_ADDR    = pc_q;
    assign bus.INSTR_VALID  = (buf_cnt != '0);
    assign bus.INSTR_OUT    = buf_head.instr;
    assign bus.INSTR_PC_OUT = buf_head.pc;

`ifdef FETCH_UNIT_TRACE_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (grant) begin
                $display("[fetch_unit] grant addr=%08h", pc_q);
            end
            if (xfer) begin
                $display("[fetch_unit] transfer instr=%08h pc=%08h", buf_head.instr, buf_head.pc);
            end
            if (bus.IMEM_RVALID && !resp_keep) begin
                $display("[fetch_unit] discard pc=%08h", trk_head.pc);
            end
            if (REDIRECT) begin
                $display("[fetch_unit] redirect target=%08h", word_align(REDIRECT_PC));
            end
        end
    end
`else
    // Trace disabled: nothing beyond the datapath is elaborated.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit, scored against a program-order
// model: expected fetch stream, epoch-tagged memory responses and a delivery queue.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RstPc  = 32'hBFC0_0000;
    localparam int          MaxOut = 2;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned ready;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FETCH_EN;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RstPc),
        .MAX_OUT  (MaxOut)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FETCH_EN    (FETCH_EN),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .bus         (bus)
    );

    always #5 CLK = ~CLK;

    req_t        pend[$];
    ent_t        exp_q[$];
    logic [31:0] grant_log[$];
    int unsigned tests, fails, cyc, epoch;
    int unsigned n_grant, n_xfer, n_disc;
    int unsigned gnt_prob, rv_prob;
    logic [31:0] exp_addr, last_xfer_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // One clock cycle, entered just after a falling edge with the control inputs already set.
    task automatic cycle();
        logic        gnt, rv, req;
        logic [31:0] addr;
        int unsigned old_epoch, stale;
        req_t        r;
        ent_t        e;
        gnt = ($urandom_range(99) < gnt_prob);
        rv  = (pend.size() != 0) && (pend[0].ready <= cyc) && ($urandom_range(99) < rv_prob);
        bus.IMEM_GNT    = gnt;
        bus.IMEM_RVALID = rv;
        if (rv) bus.IMEM_RDATA = mem_word(pend[0].addr);
        else    bus.IMEM_RDATA = $urandom;
        #1;
        req  = bus.IMEM_REQ;
        addr = bus.IMEM_ADDR;
        chk("instr_valid", 32'(bus.INSTR_VALID), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("instr_out", bus.INSTR_OUT, exp_q[0].instr);
            chk("instr_pc", bus.INSTR_PC_OUT, exp_q[0].pc);
        end
        if (req) begin
            stale = 0;
            foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
            chk("credit", 32'(pend.size() + exp_q.size() < MaxOut), 32'd1);
            chk("req_in_flush", stale, 32'd0);
            chk("imem_addr", addr, exp_addr);
        end
        if ((exp_q.size() != 0) && !bus.STALL_IN) begin
            e = exp_q.pop_front();
            last_xfer_pc = e.pc;
            n_xfer++;
        end
        old_epoch = epoch;
        if (REDIRECT) begin
            epoch++;
            exp_q.delete();
            exp_addr = REDIRECT_PC & 32'hFFFF_FFFC;
        end
        if (rv) begin
            r = pend.pop_front();
            if (r.epoch == epoch) begin
                e = '{instr: mem_word(r.addr), pc: r.addr};
                exp_q.push_back(e);
            end else begin
                n_disc++;
            end
        end
        if (req && gnt) begin
            r = '{addr: addr, epoch: old_epoch, ready: cyc + 1};
            pend.push_back(r);
            grant_log.push_back(addr);
            n_grant++;
            if (!REDIRECT) exp_addr = exp_addr + 32'd4;
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        FETCH_EN = 1'b0;
        REDIRECT = 1'b0;
        bus.STALL_IN = 1'b0;
        gnt_prob = 100;
        rv_prob = 100;
        while ((pend.size() != 0 || exp_q.size() != 0) && n < 100) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 32'(pend.size() + exp_q.size()), 32'd0);
        run(3);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_imem_req"}, 32'(bus.IMEM_REQ), 32'd0);
        chk({tag, "_instr_valid"}, 32'(bus.INSTR_VALID), 32'd0);
        chk({tag, "_instr_out"}, bus.INSTR_OUT, 32'd0);
        chk({tag, "_instr_pc"}, bus.INSTR_PC_OUT, 32'd0);
        chk({tag, "_imem_addr"}, bus.IMEM_ADDR, RstPc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned g0, x0, d0, s2_base;
        int          gl, n;
        logic        found;
        tests = 0; fails = 0; cyc = 0; epoch = 0;
        n_grant = 0; n_xfer = 0; n_disc = 0;
        gnt_prob = 100; rv_prob = 100;
        exp_addr = RstPc; last_xfer_pc = '0;
        RESET = 1'b1; FETCH_EN = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
        bus.STALL_IN = 1'b0; bus.IMEM_GNT = 1'b0; bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = '0;

        // Reset values.
        #3;
        reset_checks("rst");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // Back-to-back grants with single-cycle memory.
        FETCH_EN = 1'b1;
        run(12);
        chk("s1_addr0", log_at(0), 32'hBFC0_0000);
        chk("s1_addr1", log_at(1), 32'hBFC0_0004);
        chk("s1_addr2", log_at(2), 32'hBFC0_0008);
        drain("s1");

        // Decode stall: credit caps the requests, then both entries flow out in order.
        FETCH_EN = 1'b1;
        bus.STALL_IN = 1'b1;
        g0 = n_grant;
        s2_base = exp_addr;
        run(10);
        chk("s2_grants", n_grant - g0, 32'd2);
        x0 = n_xfer;
        drain("s2");
        chk("s2_delivered", n_xfer - x0, 32'd2);
        chk("s2_last_pc", last_xfer_pc, s2_base + 32'd4);

        // Redirect with two requests outstanding.
        FETCH_EN = 1'b1;
        rv_prob = 0;
        g0 = n_grant;
        run(6);
        chk("s3_outstanding", n_grant - g0, 32'd2);
        d0 = n_disc;
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0100;
        cycle();
        REDIRECT = 1'b0;
        rv_prob = 100;
        gl = grant_log.size();
        run(8);
        chk("s3_discarded", n_disc - d0, 32'd2);
        chk("s3_next_addr", log_at(gl), 32'h0000_0100);

        // Redirect coincident with a grant and a response; low target bits ignored.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.IMEM_REQ && pend.size() != 0 && pend[0].ready <= cyc) found = 1'b1;
            else cycle();
        end
        chk("s4_found", 32'(found), 32'd1);
        d0 = n_disc;
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_2003;
        cycle();
        REDIRECT = 1'b0;
        x0 = n_xfer;
        n = 0;
        while (n_xfer == x0 && n < 30) begin
            cycle();
            n++;
        end
        chk("s4_delivered", 32'(n_xfer > x0), 32'd1);
        chk("s4_discarded", n_disc - d0, 32'd2);
        chk("s4_first_pc", last_xfer_pc, 32'h0000_2000);

        // Address wrap at the top of the address space.
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFF8;
        cycle();
        REDIRECT = 1'b0;
        gl = grant_log.size();
        run(15);
        chk("s5_addr0", log_at(gl), 32'hFFFF_FFF8);
        chk("s5_addr1", log_at(gl + 1), 32'hFFFF_FFFC);
        chk("s5_addr2", log_at(gl + 2), 32'h0000_0000);

        // Asynchronous reset while fetching with a full buffer.
        bus.STALL_IN = 1'b1;
        n = 0;
        while (exp_q.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("s6_full", 32'(bus.INSTR_VALID), 32'd1);
        #2;
        RESET = 1'b1;
        bus.IMEM_GNT = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        #1;
        reset_checks("s6_rst");
        pend.delete();
        exp_q.delete();
        exp_addr = RstPc;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        bus.STALL_IN = 1'b0;
        FETCH_EN = 1'b1;
        gl = grant_log.size();
        run(6);
        chk("s6_first_addr", log_at(gl), RstPc);

        // Randomized traffic: sporadic grants, responses, stalls, enables and redirects.
        x0 = n_xfer;
        gnt_prob = 70;
        rv_prob = 60;
        for (int i = 0; i < 600; i++) begin
            FETCH_EN = ($urandom_range(99) < 90);
            bus.STALL_IN = ($urandom_range(99) < 30);
            REDIRECT = ($urandom_range(99) < 4);
            REDIRECT_PC = $urandom;
            cycle();
        end
        chk("rand_progress", 32'(n_xfer > x0), 32'd1);
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
